// File: rtl/br_fifo_shared_pstatic_push_arb.sv
// Round-robin merge of per-FIFO push streams into one registered push port; 1-cycle latency.
// Backpressure: held entry stays stable until push_ready; inputs to full FIFOs are skipped.
module br_fifo_shared_pstatic_push_arb #(
  parameter int NumFifos      = 2,
  parameter int Width         = 1,
  parameter bit MaskFullFifos = 1'b1,
  localparam int FifoIdWidth  = (NumFifos > 1) ? $clog2(NumFifos) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NumFifos-1:0]       in_valid,
  output logic [NumFifos-1:0]       in_ready,
  input  logic [NumFifos*Width-1:0] in_data,
  output logic                      push_valid,
  input  logic                      push_ready,
  output logic [Width-1:0]          push_data,
  output logic [FifoIdWidth-1:0]    push_fifo_id,
  input  logic [NumFifos-1:0]       push_full
);

  logic                   load_en;
  logic [NumFifos-1:0]    elig;
  logic [NumFifos-1:0]    grant;
  logic [FifoIdWidth-1:0] grant_idx;
  logic                   grant_any;
  logic [FifoIdWidth-1:0] rr_ptr;

  assign load_en = !push_valid || push_ready;
  assign elig    = in_valid & ~(push_full & {NumFifos{MaskFullFifos}});

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    // Scan from the pointer and wrap, taking the first eligible input.
    for (int k = 0; k < NumFifos; k++) begin
      idx = (int'(rr_ptr) + k) % NumFifos;
      if (!grant_any && elig[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = FifoIdWidth'(idx);
      end
    end
  end

  assign in_ready = (load_en && !rst) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      push_valid   <= 1'b0;
      push_data    <= '0;
      push_fifo_id <= '0;
      rr_ptr       <= '0;
    end else if (load_en) begin
      push_valid <= grant_any;
      if (grant_any) begin
        push_data    <= in_data[int'(grant_idx)*Width +: Width];
        push_fifo_id <= grant_idx;
        rr_ptr       <= (grant_idx == FifoIdWidth'(NumFifos - 1)) ? '0
                                                                   : grant_idx + FifoIdWidth'(1);
      end
    end
  end

  a_in_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready))
    else $error("FAIL assert in_ready_onehot0");
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
      push_valid && !push_ready |=> push_valid && $stable(push_data) && $stable(push_fifo_id))
    else $error("FAIL assert hold_stable");
  a_id_range: assert property (@(posedge clk) disable iff (rst)
      push_valid |-> int'(push_fifo_id) < NumFifos)
    else $error("FAIL assert fifo_id_range");
  a_no_x: assert property (@(posedge clk) disable iff (rst)
      !$isunknown({push_valid, push_data, push_fifo_id}))
    else $error("FAIL assert push_no_x");

endmodule

// File: tb/tb_br_fifo_shared_pstatic_push_arb.sv
// Randomized + directed bench for the shared-FIFO push arbiter with a queue-based scoreboard.
module tb_br_fifo_shared_pstatic_push_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   push_full = '0;
  logic           push_ready = 1'b0;
  logic [N*W-1:0] in_data = '0;

  logic [N-1:0]   in_ready, in_ready_nm;
  logic           push_valid, push_valid_nm;
  logic [W-1:0]   push_data, push_data_nm;
  logic [1:0]     push_fifo_id, push_fifo_id_nm;

  always #5 clk = ~clk;

  br_fifo_shared_pstatic_push_arb #(.NumFifos(N), .Width(W), .MaskFullFifos(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .push_fifo_id(push_fifo_id), .push_full(push_full));

  br_fifo_shared_pstatic_push_arb #(.NumFifos(N), .Width(W), .MaskFullFifos(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nm), .in_data(in_data),
    .push_valid(push_valid_nm), .push_ready(push_ready), .push_data(push_data_nm),
    .push_fifo_id(push_fifo_id_nm), .push_full(push_full));

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  bit    mdl_valid = 1'b0;
  int    mdl_ptr   = 0;
  int    errors    = 0;
  int    checks    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  // One clock of stimulus; the reference model decides the winner from plain rules:
  // the output slot can take a beat when empty or draining, and the winner is the first
  // requesting, non-full input counting up from the slot after the last winner.
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N-1:0] f,
                       input logic pr, input logic [N*W-1:0] d);
    int g;
    bit can_take;
    bit nv;
    int np;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst = r; in_valid = v; push_full = f; push_ready = pr; in_data = d;
    #1;
    g = -1; nv = mdl_valid; np = mdl_ptr;
    can_take = !mdl_valid || pr;
    if (r) begin
      nv = 1'b0; np = 0;
    end else if (can_take) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(mdl_ptr + k) % N] && !f[(mdl_ptr + k) % N]) g = (mdl_ptr + k) % N;
      end
      nv = (g >= 0);
      if (g >= 0) begin
        exp_q.push_back('{g, d[g*W +: W]});
        np = (g + 1) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (!r && pr && $onehot(v)) check("in_ready_nomask", 64'(in_ready_nm), 64'(v));
    @(posedge clk);
    mdl_valid = nv;
    mdl_ptr   = np;
    if (r) exp_q.delete();
  endtask

  // Monitor: samples between negedge and posedge, compares the held beat with the queue head
  // every cycle and retires it on the handshake.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        check("push_valid", 64'(push_valid), 64'(mdl_valid));
        if (push_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: id %0d data %0h with empty scoreboard", push_fifo_id, push_data);
          end else begin
            b = exp_q[0];
            check("push_fifo_id", 64'(push_fifo_id), 64'(b.id));
            check("push_data", 64'(push_data), 64'(b.data));
            if (push_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rv, rf;
    cycle(1'b1, '0, '0, 1'b1, '0);
    cycle(1'b1, '0, '0, 1'b1, '0);
    #1;
    check("reset_push_valid", 64'(push_valid), 64'd0);
    check("reset_push_data", 64'(push_data), 64'd0);
    check("reset_push_fifo_id", 64'(push_fifo_id), 64'd0);

    // All requesting: rotation 0,1,2,3,0...
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'hF, 4'h0, 1'b1, rand_data());

    // Input 0 masked by full: only input 2 wins, then 0 returns once unmasked.
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0101, 4'b0001, 1'b1, rand_data());
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'b0101, 4'b0000, 1'b1, rand_data());
    cycle(1'b0, 4'b0000, 4'b0000, 1'b1, rand_data());

    // A5 for fifo 3 held through 5 cycles of backpressure.
    cycle(1'b0, 4'b1000, 4'h0, 1'b1, {8'hA5, 24'h000000});
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'hF, 4'h0, 1'b0, rand_data());
    cycle(1'b0, 4'h0, 4'h0, 1'b1, rand_data());

    // Held entry for fifo 1 survives its FIFO going full; unmasked instance still grants a full input.
    cycle(1'b0, 4'b0010, 4'h0, 1'b1, rand_data());
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'hF, 4'b0010, 1'b0, rand_data());
    cycle(1'b0, 4'b0000, 4'b0010, 1'b1, rand_data());
    cycle(1'b0, 4'b0001, 4'b0001, 1'b1, rand_data());
    cycle(1'b0, 4'b0000, 4'b0000, 1'b1, rand_data());

    // Single stream on input 2 with push_ready toggling.
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'b0100, 4'h0, (i % 2) == 0, rand_data());

    // Reset with an entry held, then rotation restarts from input 0.
    cycle(1'b0, 4'hF, 4'h0, 1'b0, rand_data());
    cycle(1'b0, 4'hF, 4'h0, 1'b0, rand_data());
    cycle(1'b1, 4'hF, 4'h0, 1'b0, rand_data());
    cycle(1'b0, 4'h0, 4'h0, 1'b0, rand_data());
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'hF, 4'h0, 1'b1, rand_data());

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      rv = N'($urandom);
      rf = (($urandom % 4) == 0) ? N'($urandom) : '0;
      cycle(($urandom % 97) == 0, rv, rf, ($urandom % 3) != 0, rand_data());
    end

    cycle(1'b0, 4'h0, 4'h0, 1'b1, rand_data());
    cycle(1'b0, 4'h0, 4'h0, 1'b1, rand_data());
    @(negedge clk);
    #3;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
